// File: rtl/ex_commit_arb.sv
// ex_commit_arb -- register-file write-port arbiter for the execute units.
//
// Each execute unit (ALU, MUL, DIV, LSU, ...) holds a registered result plus
// a valid flag. One unit is granted per cycle. Losers are stalled so they
// keep their result stable. The granted result is registered onto the
// writeback bus with one cycle of latency.
//
// Build option:
//   COMMIT_ARB_ROUND_ROBIN_EN  defined   -> rotating priority. A pointer
//                                           remembers the unit after the last
//                                           winner, so every continuously
//                                           valid unit wins within NUM_UNITS
//                                           cycles.
//                              undefined -> fixed priority. Unit 0 is highest.
//                                           There is no pointer register.
//
// Parameters:
//   NUM_UNITS  number of requesting execute units (2..8)
//   DATA_W     result width
//   RN_W       destination register-number width
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   unit_valid    [NUM_UNITS]         unit i holds a result awaiting commit
//   unit_data     [NUM_UNITS*DATA_W]  unit i result at [i*DATA_W +: DATA_W]
//   unit_rn       [NUM_UNITS*RN_W]    unit i destination at [i*RN_W +: RN_W]
//   unit_stall    [NUM_UNITS]         unit i must hold its output register
//   wb_stall      register file cannot accept a write this cycle
//   wb_en         writeback strobe (registered)
//   wb_rn         writeback destination register (registered)
//   wb_data       writeback data (registered)
//   grant_onehot  [NUM_UNITS]         combinational grant (debug / scoreboard)
module ex_commit_arb #(
  parameter int NUM_UNITS = 4,
  parameter int DATA_W    = 64,
  parameter int RN_W      = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_UNITS-1:0]        unit_valid,
  input  logic [NUM_UNITS*DATA_W-1:0] unit_data,
  input  logic [NUM_UNITS*RN_W-1:0]   unit_rn,
  output logic [NUM_UNITS-1:0]        unit_stall,
  input  logic                        wb_stall,
  output logic                        wb_en,
  output logic [RN_W-1:0]             wb_rn,
  output logic [DATA_W-1:0]           wb_data,
  output logic [NUM_UNITS-1:0]        grant_onehot
);

  localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  // Per-unit views of the flattened result and destination buses.
  logic [DATA_W-1:0] data_arr [NUM_UNITS];
  logic [RN_W-1:0]   rn_arr   [NUM_UNITS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
      assign data_arr[gi] = unit_data[gi*DATA_W +: DATA_W];
      assign rn_arr[gi]   = unit_rn[gi*RN_W +: RN_W];
      // A register-file stall freezes every unit. Otherwise only a valid
      // unit that lost arbitration holds. A winner is free to load its next
      // result in the same cycle.
      assign unit_stall[gi] = wb_stall | (unit_valid[gi] & ~grant_onehot[gi]);
    end
  endgenerate

  // Index where the priority search starts.
  logic [IDX_W-1:0] base;
  logic             grant_any;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] cand;

`ifdef COMMIT_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr;

  assign base = ptr;

  // The pointer moves to the unit after the winner. It also moves after a
  // grant to R0 that is only being discarded. It holds when there is no
  // grant, which includes the cycles where wb_stall blocks all grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant_any) begin
      if (grant_idx == IDX_W'(NUM_UNITS - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= grant_idx + 1'b1;
      end
    end
  end
`else
  assign base = '0;
`endif

  // Search for the first valid unit, starting at base and wrapping modulo
  // NUM_UNITS. In the fixed-priority build base is 0, so the search starts
  // at unit 0.
  always_comb begin
    grant_onehot = '0;
    grant_any    = 1'b0;
    grant_idx    = '0;
    cand         = '0;
    if (!wb_stall) begin
      for (int off = 0; off < NUM_UNITS; off++) begin
        cand = IDX_W'((int'(base) + off) % NUM_UNITS);
        if (!grant_any && unit_valid[cand]) begin
          grant_any          = 1'b1;
          grant_idx          = cand;
          grant_onehot[cand] = 1'b1;
        end
      end
    end
  end

  // Writeback register.
  // R0 is hard-wired to zero. A grant to rn 0 still retires the unit's
  // result, but no write is issued. In that case the bus keeps its last
  // written contents, just as it does when there is no grant at all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_en   <= 1'b0;
      wb_rn   <= '0;
      wb_data <= '0;
    end else if (grant_any && (rn_arr[grant_idx] != '0)) begin
      wb_en   <= 1'b1;
      wb_rn   <= rn_arr[grant_idx];
      wb_data <= data_arr[grant_idx];
    end else begin
      wb_en   <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  // Protocol monitor, simulation only.
  // A unit that was valid and stalled at the last edge must still be valid
  // now. If it dropped valid, its pending result was lost.
  logic [NUM_UNITS-1:0] held_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_valid <= '0;
    end else begin
      if ((held_valid & ~unit_valid) != '0) begin
        $error("ex_commit_arb: stalled unit dropped valid (held=%b valid=%b)",
               held_valid, unit_valid);
      end
      held_valid <= unit_valid & unit_stall;
    end
  end
`endif

endmodule

// File: tb/tb_ex_commit_arb.sv
// Testbench for ex_commit_arb (NUM_UNITS=4, DATA_W=64, RN_W=6).
// The reference model is a plain priority pick over a rotating start index,
// plus the expected writeback contents. It follows COMMIT_ARB_ROUND_ROBIN_EN
// the same way the design does.
module tb_ex_commit_arb;
  localparam int N  = 4;
  localparam int DW = 64;
  localparam int RW = 6;
`ifdef COMMIT_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      unit_valid = '0;
  logic [N*DW-1:0]   unit_data;
  logic [N*RW-1:0]   unit_rn;
  logic [N-1:0]      unit_stall;
  logic              wb_stall = 1'b0;
  logic              wb_en;
  logic [RW-1:0]     wb_rn;
  logic [DW-1:0]     wb_data;
  logic [N-1:0]      grant_onehot;

  logic [DW-1:0] u_data [N];
  logic [RW-1:0] u_rn   [N];

  always_comb begin
    unit_data = '0;
    unit_rn   = '0;
    for (int i = 0; i < N; i++) begin
      unit_data[i*DW +: DW] = u_data[i];
      unit_rn[i*RW +: RW]   = u_rn[i];
    end
  end

  ex_commit_arb #(.NUM_UNITS(N), .DATA_W(DW), .RN_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .unit_valid(unit_valid), .unit_data(unit_data),
    .unit_rn(unit_rn), .unit_stall(unit_stall), .wb_stall(wb_stall),
    .wb_en(wb_en), .wb_rn(wb_rn), .wb_data(wb_data), .grant_onehot(grant_onehot)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  int            m_ptr = 0;
  logic          m_wb_en = 1'b0;
  logic [RW-1:0] m_wb_rn = '0;
  logic [DW-1:0] m_wb_data = '0;
  logic [N-1:0]  exp_grant, exp_stall;
  int            exp_k;

  // Returns the winning unit, or -1 when there is no grant.
  function automatic int pick(logic [N-1:0] v, logic s, int p);
    if (s) return -1;
    for (int k = 0; k < N; k++) begin
      int u;
      u = RR ? (p + k) % N : k;
      if (v[u]) return u;
    end
    return -1;
  endfunction

  task automatic new_result(input int i, input bit allow_zero);
    u_data[i] = {$urandom, $urandom};
    if (allow_zero && $urandom_range(0, 7) == 0) u_rn[i] = '0;
    else u_rn[i] = RW'($urandom_range(1, 63));
  endtask

  // Apply inputs at the falling edge and compute the expected combinational outputs.
  task automatic drive(input logic [N-1:0] v, input logic s);
    @(negedge clk);
    unit_valid = v;
    wb_stall   = s;
    #1;
    exp_k     = pick(v, s, m_ptr);
    exp_grant = '0;
    if (exp_k >= 0) exp_grant[exp_k] = 1'b1;
    for (int i = 0; i < N; i++) exp_stall[i] = s | (v[i] & (i != exp_k));
  endtask

  // Advance through the rising edge and update the writeback / pointer model.
  task automatic clock_edge();
    @(posedge clk);
    if (exp_k >= 0) begin
      if (u_rn[exp_k] != '0) begin
        m_wb_en   = 1'b1;
        m_wb_rn   = u_rn[exp_k];
        m_wb_data = u_data[exp_k];
      end else begin
        m_wb_en = 1'b0;
      end
      if (RR) m_ptr = (exp_k + 1) % N;
    end else begin
      m_wb_en = 1'b0;
    end
    #1;
  endtask

  // Retire whatever is still pending so the next scenario starts clean.
  task automatic drain();
    logic [N-1:0] v;
    v = unit_valid;
    for (int c = 0; c < 2 * N && v != '0; c++) begin
      drive(v, 1'b0);
      clock_edge();
      v = v & ~exp_grant;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) new_result(i, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (wb_en !== 1'b0) begin n_fail++; $display("FAIL reset_wb_en: got %b want 0", wb_en); end
    n_tests++; if (wb_rn !== '0) begin n_fail++; $display("FAIL reset_wb_rn: got %0d want 0", wb_rn); end
    n_tests++; if (wb_data !== '0) begin n_fail++; $display("FAIL reset_wb_data: got %h want 0", wb_data); end
    @(negedge clk);
    rst_n = 1'b1;
    drive('0, 1'b0);
    n_tests++; if (grant_onehot !== 4'b0000) begin n_fail++; $display("FAIL idle_grant: got %b want 0000", grant_onehot); end
    n_tests++; if (unit_stall !== 4'b0000) begin n_fail++; $display("FAIL idle_stall: got %b want 0000", unit_stall); end
    clock_edge();
  endtask

  task automatic test_single();
    u_rn[0]   = RW'(5);
    u_data[0] = 64'hDEAD;
    drive(4'b0001, 1'b0);
    n_tests++; if (grant_onehot !== exp_grant) begin n_fail++; $display("FAIL single_grant: got %b want %b", grant_onehot, exp_grant); end
    n_tests++; if (unit_stall !== exp_stall) begin n_fail++; $display("FAIL single_stall: got %b want %b", unit_stall, exp_stall); end
    clock_edge();
    n_tests++; if (wb_en !== m_wb_en) begin n_fail++; $display("FAIL single_wb_en: got %b want %b", wb_en, m_wb_en); end
    n_tests++; if (wb_rn !== m_wb_rn) begin n_fail++; $display("FAIL single_wb_rn: got %0d want %0d", wb_rn, m_wb_rn); end
    n_tests++; if (wb_data !== m_wb_data) begin n_fail++; $display("FAIL single_wb_data: got %h want %h", wb_data, m_wb_data); end
  endtask

  task automatic test_all_valid();
    drain();
    for (int i = 0; i < N; i++) begin
      new_result(i, 1'b0);
      u_rn[i] = RW'(10 + i);
    end
    for (int c = 0; c < N; c++) begin
      drive(4'b1111, 1'b0);
      n_tests++; if (grant_onehot !== exp_grant) begin n_fail++; $display("FAIL all_grant c%0d: got %b want %b", c, grant_onehot, exp_grant); end
      n_tests++; if (unit_stall !== exp_stall) begin n_fail++; $display("FAIL all_stall c%0d: got %b want %b", c, unit_stall, exp_stall); end
      clock_edge();
      n_tests++; if (wb_rn !== m_wb_rn || wb_en !== m_wb_en) begin n_fail++; $display("FAIL all_wb c%0d: got en=%b rn=%0d want en=%b rn=%0d", c, wb_en, wb_rn, m_wb_en, m_wb_rn); end
      if (exp_k >= 0) u_data[exp_k] = {$urandom, $urandom};
    end
  endtask

  task automatic test_wb_stall();
    drive(4'b1111, 1'b1);
    n_tests++; if (unit_stall !== exp_stall) begin n_fail++; $display("FAIL wbst_stall: got %b want %b", unit_stall, exp_stall); end
    n_tests++; if (grant_onehot !== exp_grant) begin n_fail++; $display("FAIL wbst_grant: got %b want %b", grant_onehot, exp_grant); end
    clock_edge();
    n_tests++; if (wb_en !== m_wb_en) begin n_fail++; $display("FAIL wbst_wb_en: got %b want %b", wb_en, m_wb_en); end
    drive(4'b1111, 1'b0);
    n_tests++; if (grant_onehot !== exp_grant) begin n_fail++; $display("FAIL wbst_resume: got %b want %b", grant_onehot, exp_grant); end
    clock_edge();
    n_tests++; if (wb_en !== m_wb_en || wb_data !== m_wb_data) begin n_fail++; $display("FAIL wbst_resume_wb: got en=%b data=%h want en=%b data=%h", wb_en, wb_data, m_wb_en, m_wb_data); end
  endtask

  task automatic test_zero_rn();
    drain();
    u_rn[2] = '0;
    drive(4'b0100, 1'b0);
    n_tests++; if (unit_stall !== exp_stall) begin n_fail++; $display("FAIL zero_stall: got %b want %b", unit_stall, exp_stall); end
    n_tests++; if (grant_onehot !== exp_grant) begin n_fail++; $display("FAIL zero_grant: got %b want %b", grant_onehot, exp_grant); end
    clock_edge();
    n_tests++; if (wb_en !== m_wb_en) begin n_fail++; $display("FAIL zero_wb_en: got %b want %b", wb_en, m_wb_en); end
    u_rn[2] = RW'(7);
    drive(4'b1111, 1'b0);
    n_tests++; if (grant_onehot !== exp_grant) begin n_fail++; $display("FAIL zero_ptr_next: got %b want %b", grant_onehot, exp_grant); end
    clock_edge();
  endtask

  task automatic test_fairness();
    bit got3;
    drain();
    got3 = 1'b0;
    for (int i = 0; i < N; i++) new_result(i, 1'b0);
    for (int c = 0; c <= N; c++) begin
      drive((c == 0) ? 4'b0001 : 4'b1001, 1'b0);
      n_tests++; if (grant_onehot !== exp_grant || unit_stall !== exp_stall) begin n_fail++; $display("FAIL fair c%0d: got grant=%b stall=%b want grant=%b stall=%b", c, grant_onehot, unit_stall, exp_grant, exp_stall); end
      if (grant_onehot[3]) got3 = 1'b1;
      clock_edge();
      if (exp_k == 0) new_result(0, 1'b0);
    end
    n_tests++; if (got3 !== RR) begin n_fail++; $display("FAIL fair_unit3_granted: got %b want %b", got3, RR); end
  endtask

  task automatic test_async_reset();
    drain();
    for (int i = 0; i < N; i++) new_result(i, 1'b0);
    drive(4'b1111, 1'b0);
    clock_edge();
    n_tests++; if (wb_en !== m_wb_en) begin n_fail++; $display("FAIL areset_pre_wb_en: got %b want %b", wb_en, m_wb_en); end
    #2;
    rst_n = 1'b0;
    #1;
    m_ptr = 0; m_wb_en = 1'b0; m_wb_rn = '0; m_wb_data = '0;
    n_tests++; if (wb_en !== 1'b0) begin n_fail++; $display("FAIL areset_wb_en: got %b want 0", wb_en); end
    n_tests++; if (wb_rn !== '0) begin n_fail++; $display("FAIL areset_wb_rn: got %0d want 0", wb_rn); end
    n_tests++; if (wb_data !== '0) begin n_fail++; $display("FAIL areset_wb_data: got %h want 0", wb_data); end
    unit_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1111, 1'b0);
    n_tests++; if (grant_onehot !== 4'b0001) begin n_fail++; $display("FAIL areset_first_grant: got %b want 0001", grant_onehot); end
    clock_edge();
    n_tests++; if (wb_rn !== m_wb_rn || wb_data !== m_wb_data) begin n_fail++; $display("FAIL areset_first_wb: got rn=%0d data=%h want rn=%0d data=%h", wb_rn, wb_data, m_wb_rn, m_wb_data); end
  endtask

  task automatic test_random();
    logic [N-1:0] v, keep;
    logic s;
    drain();
    keep = '0;
    for (int c = 0; c < 300; c++) begin
      v = '0;
      for (int i = 0; i < N; i++) begin
        if (keep[i]) v[i] = 1'b1;
        else if ($urandom_range(0, 2) != 0) begin
          v[i] = 1'b1;
          new_result(i, 1'b1);
        end
      end
      s = ($urandom_range(0, 4) == 0);
      drive(v, s);
      n_tests++; if (grant_onehot !== exp_grant) begin n_fail++; $display("FAIL rand_grant c%0d: got %b want %b", c, grant_onehot, exp_grant); end
      n_tests++; if (unit_stall !== exp_stall) begin n_fail++; $display("FAIL rand_stall c%0d: got %b want %b", c, unit_stall, exp_stall); end
      clock_edge();
      n_tests++; if (wb_en !== m_wb_en) begin n_fail++; $display("FAIL rand_wb_en c%0d: got %b want %b", c, wb_en, m_wb_en); end
      if (m_wb_en) begin
        n_tests++; if (wb_rn !== m_wb_rn || wb_data !== m_wb_data) begin n_fail++; $display("FAIL rand_wb c%0d: got rn=%0d data=%h want rn=%0d data=%h", c, wb_rn, wb_data, m_wb_rn, m_wb_data); end
      end
      keep = v & exp_stall;
    end
  endtask

  initial begin
    test_reset();
    $display("[TB] reset done, failures so far %0d", n_fail);
    test_single();
    $display("[TB] single request done, failures so far %0d", n_fail);
    test_all_valid();
    $display("[TB] all-valid burst done, failures so far %0d", n_fail);
    test_wb_stall();
    $display("[TB] wb_stall done, failures so far %0d", n_fail);
    test_zero_rn();
    $display("[TB] zero-register done, failures so far %0d", n_fail);
    test_fairness();
    $display("[TB] fairness done (round robin=%0d), failures so far %0d", RR, n_fail);
    test_async_reset();
    $display("[TB] async reset done, failures so far %0d", n_fail);
    test_random();
    $display("[TB] random traffic done, failures so far %0d", n_fail);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ex_commit_arb.md
Name: ex_commit_arb

Overview:
- Arbitrates the single register-file write port among NUM_UNITS execute units (ALU, MUL, DIV, LSU).
- Each unit presents a registered result and a valid flag. The arbiter grants one unit per cycle and stalls the losers so they hold their result.
- Granted results are registered onto the writeback bus.
- Sits between the execute units' output registers and the register file / scoreboard clear logic.

Parameters:
- NUM_UNITS, 4, number of requesting execute units (2..8).
- DATA_W, 64, result width.
- RN_W, 6, destination register-number width.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- unit_valid  input  NUM_UNITS  bit i: unit i holds a result awaiting commit
- unit_data  input  NUM_UNITS*DATA_W  unit i result at bits [i*DATA_W +: DATA_W]
- unit_rn  input  NUM_UNITS*RN_W  unit i destination at bits [i*RN_W +: RN_W]
- unit_stall  output  NUM_UNITS  bit i: unit i must hold its output register this cycle
- wb_stall  input  1  register file cannot accept a write this cycle
- wb_en  output  1  writeback strobe
- wb_rn  output  RN_W  writeback destination register
- wb_data  output  DATA_W  writeback data
- grant_onehot  output  NUM_UNITS  combinational grant, for debug and scoreboard

Behaviour:
- Reset (async, rst_n low): wb_en=0, wb_rn=0, wb_data=0, priority pointer ptr=0.
- Combinational arbitration:
  - If wb_stall=1, grant_onehot=0.
  - Otherwise grant_onehot selects exactly one valid unit: the first set bit of unit_valid searching from ptr upward, modulo NUM_UNITS.
  - No valid units -> grant_onehot=0.
- unit_stall[i] = wb_stall | (unit_valid[i] & ~grant_onehot[i]).
  - Idle units (valid=0) are not stalled unless wb_stall=1.
  - A granted unit sees stall=0, so it may load its next result in the same cycle.
- Writeback register, 1-cycle latency:
  - On clk rise, if grant to unit k: wb_en<=1, wb_rn<=unit_rn[k], wb_data<=unit_data[k].
  - Otherwise wb_en<=0; wb_rn and wb_data hold.
- Zero-register rule: a grant whose unit_rn equals 0 still consumes the result (unit_stall=0) but drives wb_en<=0. R0 is hard-wired zero.
- ptr update:
  - On a grant to unit k, ptr<=(k+1) mod NUM_UNITS.
  - ptr holds when there is no grant or wb_stall=1.
- Fairness: with wb_stall held 0, any continuously valid unit is granted within NUM_UNITS cycles.
- Simultaneous valid from all units: one grant per cycle in rotating order. Losers' results remain stable because they are stalled.
- wb_stall asserted mid-burst:
  - All units stalled and wb_en<=0 the next cycle.
  - Arbitration resumes from the held ptr when wb_stall deasserts.
- Reset mid-operation: pending unit results are not the arbiter's responsibility. Outputs and ptr return to reset values asynchronously.
- Unit_valid changing while stalled is a protocol violation. Flag it with a simulation-only $error when a stalled-valid unit drops valid.

Optional Feature:
- Macro COMMIT_ARB_ROUND_ROBIN_EN.
- Defined: rotating priority with ptr, as above.
- Undefined:
  - Fixed priority, unit 0 highest, then unit 1, and so on.
  - ptr register removed; fairness guarantee does not apply.
  - All other behaviour is identical.

Test Plan:
- Reset, then single request: unit_valid=4'b0001, unit_rn[0]=5, unit_data[0]=64'hDEAD -> grant_onehot=0001, unit_stall=0000; next cycle wb_en=1, wb_rn=5, wb_data=64'hDEAD.
- All four valid for 4 cycles (RR enabled, ptr=0) -> grants in order 0,1,2,3; wb_rn follows each unit's rn; losers see unit_stall=1 each cycle.
- wb_stall=1 with unit_valid=1111 -> unit_stall=1111, grant_onehot=0, next wb_en=0. Release wb_stall -> grant resumes at the held ptr.
- Unit 2 valid with unit_rn=0 -> unit_stall[2]=0, next wb_en=0, ptr advances to 3.
- RR fairness: unit 0 continuously valid, unit 3 valid from cycle 1 -> unit 3 granted within 4 cycles. With the macro undefined, unit 0 wins every cycle and unit 3 stays stalled.
- Assert rst_n=0 asynchronously mid-grant, between clock edges -> wb_en=0, wb_rn=0, wb_data=0 immediately; first grant after release starts from unit 0.
